// File: rtl/fetch_unit_if.sv
// Fetch-side bundle: the address/data path to the instruction memory plus decode handshake and control.
interface fetch_unit_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] instruction;
  logic             stall;
  logic             halt;
  logic             redirect;
  logic [WIDTH-1:0] redirect_pc;
  logic [WIDTH-1:0] inst_out;
  logic [WIDTH-1:0] inst_pc;
  logic             inst_valid;

  modport master (
    input  instruction, stall, halt, redirect, redirect_pc,
    output pc, inst_out, inst_pc, inst_valid
  );

  modport slave (
    output instruction, stall, halt, redirect, redirect_pc,
    input  pc, inst_out, inst_pc, inst_valid
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: pc register, one-cycle memory response slot, one-entry skid buffer and
// output register to decode, with redirect flush and halt that only stops new issue.
module fetch_unit #(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input logic           clk,
  input logic           rst_n,
  fetch_unit_if.master  bus
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_pc_q, rsp_pc_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_inst_q, skid_inst_d;
  logic [WIDTH-1:0] skid_pc_q, skid_pc_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_inst_q, out_inst_d;
  logic [WIDTH-1:0] out_pc_q, out_pc_d;
  logic             issue;
  logic             out_free;

  always_comb begin
    pc_d         = pc_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_pc_d     = rsp_pc_q;
    skid_valid_d = skid_valid_q;
    skid_inst_d  = skid_inst_q;
    skid_pc_d    = skid_pc_q;
    out_valid_d  = out_valid_q;
    out_inst_d   = out_inst_q;
    out_pc_d     = out_pc_q;

    // A response in flight while the output is held must have somewhere to land next edge.
    issue    = !bus.halt && !skid_valid_q && !(out_valid_q && bus.stall && rsp_valid_q);
    out_free = !out_valid_q || !bus.stall;

    if (bus.redirect) begin
      pc_d         = bus.redirect_pc;
      rsp_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
      out_valid_d  = 1'b0;
    end else begin
      if (issue) begin
        rsp_valid_d = 1'b1;
        rsp_pc_d    = pc_q;
        pc_d        = pc_q + WIDTH'(1);
      end else begin
        rsp_valid_d = 1'b0;
      end

      if (out_free) begin
        if (skid_valid_q) begin
          out_valid_d  = 1'b1;
          out_inst_d   = skid_inst_q;
          out_pc_d     = skid_pc_q;
          skid_valid_d = 1'b0;
        end else if (rsp_valid_q) begin
          out_valid_d = 1'b1;
          out_inst_d  = bus.instruction;
          out_pc_d    = rsp_pc_q;
        end else begin
          out_valid_d = 1'b0;
        end
      end

      // Memory data is only valid for this one cycle, so anything not taken by the output goes to skid.
      if (rsp_valid_q && (!out_free || skid_valid_q)) begin
        skid_valid_d = 1'b1;
        skid_inst_d  = bus.instruction;
        skid_pc_d    = rsp_pc_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      rsp_valid_q  <= 1'b0;
      rsp_pc_q     <= '0;
      skid_valid_q <= 1'b0;
      skid_inst_q  <= '0;
      skid_pc_q    <= '0;
      out_valid_q  <= 1'b0;
      out_inst_q   <= '0;
      out_pc_q     <= '0;
    end else begin
      pc_q         <= pc_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_pc_q     <= rsp_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_inst_q  <= skid_inst_d;
      skid_pc_q    <= skid_pc_d;
      out_valid_q  <= out_valid_d;
      out_inst_q   <= out_inst_d;
      out_pc_q     <= out_pc_d;
    end
  end

  assign bus.pc         = pc_q;
  assign bus.inst_out   = out_inst_q;
  assign bus.inst_pc    = out_pc_q;
  assign bus.inst_valid = out_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: stimulus pushes expected deliveries into a queue, a negedge
// monitor pops and compares every transfer; direct checks cover reset, pc and timing points.
module tb_fetch_unit;

  typedef struct packed {
    logic [15:0] inst;
    logic [15:0] pc;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t exp_q[$];
  int   vectors;
  int   miscompares;

  fetch_unit_if #(.WIDTH(16)) fif ();

  fetch_unit #(.WIDTH(16), .RESET_PC(16'h0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (fif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction memory: ram[i] = A000 + i.
  always @(posedge clk) fif.instruction <= 16'hA000 + fif.pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic push(input logic [15:0] inst, input logic [15:0] pc);
    exp_t e;
    e.inst = inst;
    e.pc   = pc;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  // A transfer happens at the next rising edge whenever valid is high and stall is low.
  always @(negedge clk) begin
    if (rst_n && fif.inst_valid && !fif.stall) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_delivery: got inst %h pc %h, expected none",
                 fif.inst_out, fif.inst_pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (fif.inst_out !== e.inst || fif.inst_pc !== e.pc) begin
          miscompares++;
          $display("FAIL delivery: got inst %h pc %h, expected inst %h pc %h",
                   fif.inst_out, fif.inst_pc, e.inst, e.pc);
        end
      end
    end
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n           = 1'b0;
    fif.stall       = 1'b0;
    fif.halt        = 1'b0;
    fif.redirect    = 1'b0;
    fif.redirect_pc = 16'h0000;

    #3;
    chk("rst_pc", 32'(fif.pc), 32'h0000);
    chk("rst_valid", 32'(fif.inst_valid), 32'h0);
    chk("rst_inst_out", 32'(fif.inst_out), 32'h0000);
    chk("rst_inst_pc", 32'(fif.inst_pc), 32'h0000);

    // Addresses 0..7 are delivered in order across the stall and halt episodes below.
    for (int a = 0; a < 8; a++) push(16'hA000 + 16'(a), 16'(a));

    step(1);
    rst_n = 1'b1;
    step(1);                                      // E1: first issue
    chk("e1_valid", 32'(fif.inst_valid), 32'h0);
    chk("e1_pc", 32'(fif.pc), 32'h0001);
    step(1);                                      // E2: first delivery
    chk("e2_valid", 32'(fif.inst_valid), 32'h1);
    chk("e2_inst_pc", 32'(fif.inst_pc), 32'h0000);
    chk("e2_inst_out", 32'(fif.inst_out), 32'hA000);
    step(2);                                      // E4
    fif.stall = 1'b1;
    step(1);                                      // E5: response 3 goes to skid
    chk("stall_pc_frozen", 32'(fif.pc), 32'h0004);
    step(2);                                      // E7
    chk("stall_pc_held", 32'(fif.pc), 32'h0004);
    chk("stall_inst_pc_held", 32'(fif.inst_pc), 32'h0002);
    chk("stall_valid_held", 32'(fif.inst_valid), 32'h1);
    fif.stall = 1'b0;
    step(3);                                      // E10
    fif.halt = 1'b1;
    step(2);                                      // E12: outstanding 5 delivered, then empty
    chk("halt_valid_drop", 32'(fif.inst_valid), 32'h0);
    chk("halt_pc_held", 32'(fif.pc), 32'h0006);
    step(1);                                      // E13
    chk("halt_pc_still", 32'(fif.pc), 32'h0006);
    fif.halt = 1'b0;
    step(2);                                      // E15: resumes at 6
    chk("resume_inst_pc", 32'(fif.inst_pc), 32'h0006);
    step(2);                                      // E17
    fif.stall = 1'b1;
    step(1);                                      // E18: skid now full with 9, output holds 8
    fif.redirect    = 1'b1;
    fif.redirect_pc = 16'h0040;
    push(16'hA040, 16'h0040);
    push(16'hA041, 16'h0041);
    push(16'hA042, 16'h0042);
    step(1);                                      // E19: flush
    fif.redirect = 1'b0;
    fif.stall    = 1'b0;
    chk("redir_valid_flush", 32'(fif.inst_valid), 32'h0);
    chk("redir_pc", 32'(fif.pc), 32'h0040);
    step(2);                                      // E21: target two edges after redirect
    chk("redir_valid", 32'(fif.inst_valid), 32'h1);
    chk("redir_inst_pc", 32'(fif.inst_pc), 32'h0040);
    chk("redir_inst_out", 32'(fif.inst_out), 32'hA040);
    step(2);                                      // E23: 42 transfers at the redirect edge
    fif.redirect    = 1'b1;
    fif.redirect_pc = 16'hFFFE;
    push(16'h9FFE, 16'hFFFE);
    push(16'h9FFF, 16'hFFFF);
    push(16'hA000, 16'h0000);
    step(1);                                      // E24
    fif.redirect = 1'b0;
    step(1);                                      // E25
    chk("wrap_pc_ffff", 32'(fif.pc), 32'hFFFF);
    step(1);                                      // E26
    chk("wrap_pc_0000", 32'(fif.pc), 32'h0000);
    chk("wrap_inst_pc_fffe", 32'(fif.inst_pc), 32'hFFFE);
    step(3);                                      // E29: 0001 on output, not yet transferred
    chk("wrap_inst_pc_0001", 32'(fif.inst_pc), 32'h0001);
    chk("wrap_inst_out_0001", 32'(fif.inst_out), 32'hA001);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(fif.inst_valid), 32'h0);
    chk("async_rst_inst_out", 32'(fif.inst_out), 32'h0000);
    chk("async_rst_pc", 32'(fif.pc), 32'h0000);
    chk("async_rst_inst_pc", 32'(fif.inst_pc), 32'h0000);
    for (int a = 0; a < 5; a++) push(16'hA000 + 16'(a), 16'(a));
    #1;
    rst_n = 1'b1;
    step(1);                                      // E30
    chk("restart_e1_valid", 32'(fif.inst_valid), 32'h0);
    chk("restart_e1_pc", 32'(fif.pc), 32'h0001);
    step(1);                                      // E31
    chk("restart_valid", 32'(fif.inst_valid), 32'h1);
    chk("restart_inst_pc", 32'(fif.inst_pc), 32'h0000);
    step(3);                                      // E34
    fif.halt = 1'b1;
    step(4);
    chk("drain_valid", 32'(fif.inst_valid), 32'h0);
    chk("drain_pc", 32'(fif.pc), 32'h0005);
    chk("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter WIDTH, default 16, instruction and address width.
REQ-002 Parameter RESET_PC, default 16'h0000, first fetch address after reset.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port pc  output  WIDTH  fetch address driven to the instruction memory's pc input.
REQ-006 Port instruction  input  WIDTH  memory read data; equals ram[pc sampled at the previous rising edge].
REQ-007 Port stall  input  1  downstream decode not ready; inst_out is held while stall=1.
REQ-008 Port halt  input  1  suppresses new fetch issue; in-flight fetches still complete.
REQ-009 Port redirect  input  1  single-cycle request to restart fetch at redirect_pc (taken branch/jump).
REQ-010 Port redirect_pc  input  WIDTH  redirect target address.
REQ-011 Port inst_out  output  WIDTH  registered instruction presented to decode.
REQ-012 Port inst_pc  output  WIDTH  address inst_out was fetched from.
REQ-013 Port inst_valid  output  1  inst_out/inst_pc valid; a transfer occurs on any edge where inst_valid=1 and stall=0.

Function
REQ-014 Internal state SHALL be: pc register, response slot (rsp_valid, rsp_pc), one-entry skid buffer (skid_valid, skid_inst, skid_pc), and output register (inst_valid, inst_out, inst_pc).
REQ-015 issue SHALL be !halt & !skid_valid & !(inst_valid & stall & rsp_valid), evaluated combinationally each cycle.
REQ-016 On an edge with issue=1 and no redirect: rsp_valid<=1, rsp_pc<=pc, pc<=pc+1; with issue=0: rsp_valid<=0, pc held.
REQ-017 pc increment SHALL wrap modulo 2^WIDTH (16'hFFFF -> 16'h0000) with no flag.
REQ-018 While rsp_valid=1, instruction is the response for rsp_pc; it SHALL be captured on that edge and never dropped.
REQ-019 Output register load priority per edge when inst_valid=0 or stall=0: skid entry first, else response slot, else inst_valid<=0.
REQ-020 A response not loaded into the output register (output held under stall, or skid being drained into it) SHALL be written to the skid buffer.
REQ-021 With stall=1 and inst_valid=1, inst_out, inst_pc and inst_valid SHALL remain unchanged.
REQ-022 Delivery order SHALL equal fetch order; no instruction duplicated or lost across any stall pattern.
REQ-023 Sustained throughput with stall=0, halt=0 SHALL be one instruction per cycle.
REQ-024 Latency: an address issued at edge N SHALL appear on inst_out at edge N+1 when the output path is free.
REQ-025 redirect=1 SHALL take priority over halt, stall and issue: at that edge pc<=redirect_pc, rsp_valid<=0, skid_valid<=0, inst_valid<=0.
REQ-026 After a redirect edge R (halt=0, stall=0) the target SHALL issue at edge R+1 and appear on inst_out with inst_pc=redirect_pc at edge R+2.
REQ-027 halt=1 SHALL stop issue only; responses already in flight and in the skid buffer SHALL still be delivered.

Reset
REQ-028 rst_n=0 SHALL immediately, without a clock edge, set pc=RESET_PC, rsp_valid=0, skid_valid=0, inst_valid=0, inst_out=0, inst_pc=0.
REQ-029 Reset asserted mid-stream SHALL discard all in-flight, skid and output contents.
REQ-030 First issue SHALL occur at the first rising edge with rst_n=1 (halt=0), presenting RESET_PC.

Verification
REQ-031 Memory model ram[i]=16'hA000+i, release reset, stall=halt=0 -> inst_valid rises at 2nd edge with A000/pc 0000, then A001, A002 ... one per edge.
REQ-032 Stream running, stall=1 for 3 cycles then 0 -> skid fills once, pc freezes, delivered sequence contiguous with no gap or repeat.
REQ-033 Stall held with skid full, redirect=1, redirect_pc=16'h0040, then stall=0 -> contents flushed; next valid is A040/pc 0040 two edges after redirect.
REQ-034 redirect_pc=16'hFFFE, free-running -> inst_pc sequence FFFE, FFFF, 0000, 0001.
REQ-035 halt=1 mid-stream -> outstanding instruction delivered, inst_valid then drops, pc held; halt=0 -> resumes at held pc with no skipped address.
REQ-036 rst_n pulsed low between clock edges mid-stream -> inst_valid=0, inst_out=0, pc=RESET_PC before the next edge; restart as in REQ-031.
